div_iter: RTL
=============

Name: div_iter

Overview:
- Iterative radix-2 restoring divider for DIV/DIVU; counterpart of the two-cycle multiplier, sits beside it in EX and feeds HI/LO.
- Computes a 32-bit quotient and remainder, signed or unsigned, one bit per cycle.
- Uses valid/ready handshakes on the operand and result sides so the pipeline can stall on it.

Parameters:
- WIDTH, 32, operand/quotient/remainder width.
- CNT_W, 5, iteration counter width; must satisfy 2**CNT_W == WIDTH.

Ports:
- mul_clk  input  1  clock, all state updates on posedge.
- resetn  input  1  synchronous active-low reset.
- div_valid  input  1  operands present.
- div_ready  output  1  block can accept operands.
- div_signed  input  1  1 = DIV (two's complement), 0 = DIVU.
- x  input  WIDTH  dividend.
- y  input  WIDTH  divisor.
- result_valid  output  1  s/r valid.
- result_ready  input  1  consumer takes result.
- s  output  WIDTH  quotient (LO).
- r  output  WIDTH  remainder (HI).

Behaviour:
- Reset: resetn is synchronous, active-low, sampled on posedge mul_clk.
  - State goes to IDLE; counter, remainder and quotient registers are cleared.
  - result_valid=0, s=0, r=0. div_ready=1 from the first cycle after reset.
- States:
  - IDLE: div_ready=1. On div_valid&div_ready, go to BUSY and latch sx=div_signed&x[31], sy=div_signed&y[31], |x|, |y|, div_signed and a zero-divisor flag (y==0). Clear the counter and the 33-bit partial remainder.
  - BUSY: one restoring step per cycle.
    - Shift {rem,quo} left by 1, shifting in the next dividend bit.
    - trial = rem - {1'b0,|y|}; if trial>=0 then rem=trial and quo[0]=1, else quo[0]=0.
    - The counter increments; after the step at count 31, go to DONE.
    - div_ready=0; div_valid is ignored.
  - DONE: result_valid=1; s and r are held stable. When result_ready is sampled high, go to IDLE at that edge. No same-edge new accept.
- Latency: handshake sampled at edge N gives result_valid high after edge N+32. Minimum issue interval is 34 cycles.
- Sign rules, applied combinationally from registered magnitudes:
  - s = (sx^sy) ? -quo : quo.
  - r = sx ? -rem : rem.
- Divide by zero: sign correction is bypassed; s=all ones, r=x as originally latched. No exception is raised.
- Signed overflow (0x80000000 / -1): falls out naturally as s=0x80000000, r=0.
- Absolute values: |0x80000000| is 0x80000000 treated as unsigned; no extra width is needed beyond the 33-bit remainder.
- Operand inputs x, y and div_signed are don't-care outside the accept cycle.
- result_ready while not in DONE has no effect.
- Reset in any state aborts the operation at the next edge; no partial result appears.

Optional Feature:
- Macro: DIV_CANCEL_EN.
- Defined: adds input div_cancel (1 bit), used for pipeline flush on exception or eret.
  - div_cancel sampled high in BUSY or DONE returns the block to IDLE at that edge and drops result_valid.
  - In IDLE, div_cancel suppresses an accept in the same cycle.
  - Cancel has priority over result_ready and div_valid.
- Undefined: no port exists; an operation always runs to completion and waits in DONE.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=2'b00, BUSY=2'b01, DONE=2'b10;
  - DIV_WIDTH=32 and DIV_ITERS=32;
  - the 64-bit {HI,LO} result packing order, {r,s}, shared with the multiplier consumer.
- Sub-module div_step: purely combinational single restoring step.
  - Inputs: 33-bit rem, WIDTH quo, divisor magnitude.
  - Outputs: next rem, next quo.
  - Unit-testable standalone.
- Sign/abs logic and the FSM stay in div_iter.

Test Plan:
- Unsigned: div_signed=0, x=100, y=7 -> s=14, r=2; result_valid rises exactly 32 edges after accept.
- Signed mixed: div_signed=1, x=0xFFFFFFF9 (-7), y=2 -> s=0xFFFFFFFD (-3), r=0xFFFFFFFF (-1). Also x=7, y=0xFFFFFFFE -> s=0xFFFFFFFD, r=1.
- Corners:
  - Signed overflow: x=0x80000000, y=0xFFFFFFFF -> s=0x80000000, r=0.
  - Unsigned max: x=0xFFFFFFFF, y=1 -> s=0xFFFFFFFF, r=0.
- Divide by zero, both modes: x=0x12345678 and x=0x87654321, y=0 -> s=0xFFFFFFFF, r=x unchanged.
- Backpressure: hold result_ready low 5 cycles in DONE with div_valid=1 -> s/r stable, div_ready=0, no new accept. Raise result_ready -> IDLE next edge, the pending op accepted the following edge.
- Reset mid-op: assert resetn=0 at iteration 10 -> result_valid stays 0, div_ready=1 after release. Next op x=9, y=3 -> s=3, r=0. With DIV_CANCEL_EN, repeat using div_cancel -> same outcome.

Source files
------------

// File: rtl/div_iter_pkg.sv
// div_iter_pkg: shared constants and types for the iterative divider.
// This package holds the FSM state encoding, the datapath width and iteration
// count, and the {HI,LO} packing that the multiplier consumer also uses.
package div_iter_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_ITERS = 32;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] BUSY = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  // HI holds the remainder and LO holds the quotient, in the same order as the multiplier result.
  typedef struct packed {
    logic [DIV_WIDTH-1:0] hi;
    logic [DIV_WIDTH-1:0] lo;
  } hilo_t;

  function automatic hilo_t packHiLo(input logic [DIV_WIDTH-1:0] r,
                                     input logic [DIV_WIDTH-1:0] s);
    hilo_t res;
    res.hi = r;
    res.lo = s;
    return res;
  endfunction

endpackage

// File: rtl/div_iter_if.sv
// div_iter_if: operand/result handshake bundle between EX and the divider.
// The master side is the pipeline and the slave side is div_iter.
// When DIV_CANCEL_EN is defined, the bundle also carries div_cancel for pipeline flushes.
interface div_iter_if
  import div_iter_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
);

  logic             div_valid;
  logic             div_ready;
  logic             div_signed;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             result_valid;
  logic             result_ready;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] r;
`ifdef DIV_CANCEL_EN
  logic             div_cancel;
`endif

  modport master (
    output div_valid, div_signed, x, y, result_ready,
`ifdef DIV_CANCEL_EN
    output div_cancel,
`endif
    input  div_ready, result_valid, s, r
  );

  modport slave (
    input  div_valid, div_signed, x, y, result_ready,
`ifdef DIV_CANCEL_EN
    input  div_cancel,
`endif
    output div_ready, result_valid, s, r
  );

endinterface

// File: rtl/div_step.sv
// div_step: a single combinational radix-2 restoring division step.
// It operates on unsigned magnitudes. quo_i holds the dividend bits that are
// still unconsumed in its upper part, and finished quotient bits enter at bit 0.
module div_step
  import div_iter_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH+1:0] remShift;
  logic [WIDTH+1:0] trial;

  // Bring the next dividend bit into the remainder, then keep the subtraction only when it does not underflow.
  always_comb begin
    remShift = {rem_i, quo_i[WIDTH-1]};
    trial    = remShift - {2'b00, divisor_i};
    if (!trial[WIDTH+1]) begin
      rem_o = trial[WIDTH:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o = remShift[WIDTH:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_iter.sv
// div_iter: iterative radix-2 restoring divider for DIV/DIVU. It produces one
// quotient bit per cycle and feeds HI (r) and LO (s).
// Optional macro DIV_CANCEL_EN adds div_cancel, which flushes an operation in flight.
module div_iter
  import div_iter_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = 5
) (
  input logic       mul_clk,
  input logic       resetn,
  div_iter_if.slave bus
);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] absY_q, absY_d;
  logic             sx_q, sx_d;
  logic             sy_q, sy_d;
  logic             divZero_q, divZero_d;

  logic [WIDTH:0]   stepRem;
  logic [WIDTH-1:0] stepQuo;
  logic             cancel;
  logic             accept;
  logic             lastIter;
  logic             inSx, inSy;
  logic [WIDTH-1:0] inAbsX, inAbsY;

`ifdef DIV_CANCEL_EN
  assign cancel = bus.div_cancel;
`else
  assign cancel = 1'b0;
`endif

  assign inSx     = bus.div_signed & bus.x[WIDTH-1];
  assign inSy     = bus.div_signed & bus.y[WIDTH-1];
  assign inAbsX   = inSx ? -bus.x : bus.x;
  assign inAbsY   = inSy ? -bus.y : bus.y;
  assign accept   = (state_q == IDLE) && bus.div_valid && !cancel;
  assign lastIter = (cnt_q == {CNT_W{1'b1}});

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (absY_q),
    .rem_o     (stepRem),
    .quo_o     (stepQuo)
  );

  // Next-state logic: latch the operands on accept, take one step per BUSY cycle, and hold the result in DONE.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    absY_d    = absY_q;
    sx_d      = sx_q;
    sy_d      = sy_q;
    divZero_d = divZero_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = BUSY;
          cnt_d     = '0;
          rem_d     = '0;
          quo_d     = inAbsX;
          absY_d    = inAbsY;
          sx_d      = inSx;
          sy_d      = inSy;
          divZero_d = (bus.y == '0);
        end
      end
      BUSY: begin
        if (cancel) begin
          state_d = IDLE;
        end else begin
          rem_d = stepRem;
          quo_d = stepQuo;
          cnt_d = cnt_q + 1'b1;
          if (lastIter) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (cancel || bus.result_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; the synchronous active-low reset aborts any operation in flight.
  always_ff @(posedge mul_clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      absY_q    <= '0;
      sx_q      <= 1'b0;
      sy_q      <= 1'b0;
      divZero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      absY_q    <= absY_d;
      sx_q      <= sx_d;
      sy_q      <= sy_d;
      divZero_q <= divZero_d;
    end
  end

  assign bus.div_ready    = (state_q == IDLE);
  assign bus.result_valid = (state_q == DONE);

  // The quotient skips sign correction on divide-by-zero, so the all-ones pattern reaches s unchanged.
  // A zero divisor leaves |x| in rem. Restoring the dividend's sign to that value gives back
  // the original x, so r needs no separate copy of the operand.
  assign bus.s = ((sx_q ^ sy_q) && !divZero_q) ? -quo_q : quo_q;
  assign bus.r = sx_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

endmodule
